// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time on the
// memory port, and hands the fetched word plus its PC to decode. A redirect
// from execute replaces the PC and discards whatever fetch is in flight.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;

    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_plus4;

    // Redirect targets are word aligned; the low two bits are simply ignored.
    always_comb begin
        redirect_target      = redirect_pc;
        redirect_target[1:0] = 2'b00;
        pc_plus4             = pc_q + XLEN'(4);
    end

    // Port outputs; both valids are held low while reset is asserted because
    // the state itself only clears on the next rising edge.
    always_comb begin
        req_valid  = 1'b0;
        inst_valid = 1'b0;
        if (!rst) begin
            req_valid  = (state_q == ST_REQ) && !redirect_valid && !halt;
            inst_valid = (state_q == ST_HOLD);
        end
        req_addr = pc_q;
        inst     = inst_q;
        inst_pc  = inst_pc_q;
    end

    // Next-state logic; a redirect always wins over the sequential PC advance.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        unique case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else if (req_valid && req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_d    = rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_plus4;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State registers with synchronous reset that overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_REQ;
            pc_q      <= XLEN'(RESET_PC);
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

endmodule
